round_robin_arbiter: RTL

- Parametrised N-requester arbiter with a registered one-hot grant and a request/acknowledge handshake; generalises the combinational one-hot priority encoder.
- Selectable mode: rotating (round-robin) priority or fixed LSB-first priority.
- Sits in front of shared resources (bus ports, shared memories, FIFO write ports) in libsv-based designs.

---
 rtl/round_robin_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/round_robin_arbiter.sv
// N-requester arbiter with a registered one-hot grant, held until ack or withdrawal.
// Optional burst lock is enabled by defining LIBSV_ROUND_ROBIN_ARBITER_LOCK_EN.
module round_robin_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned MODE = 0,
    parameter int unsigned IDXW = $clog2(N)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N-1:0]    i_req,
    input  logic            i_ack,
`ifdef LIBSV_ROUND_ROBIN_ARBITER_LOCK_EN
    input  logic            i_lock,
`endif
    output logic [N-1:0]    o_gnt,
    output logic [IDXW-1:0] o_gnt_idx,
    output logic            o_valid
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [N-1:0] One = {{(N-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic            valid_q, valid_d;

    logic [IDXW-1:0] arb_ptr;
    logic [IDXW-1:0] win_idx;
    logic [IDXW-1:0] cand;
    logic            win_found;
    logic            lock_hold;

    // While granting, an ack re-arbitrates as if ptr had already moved to the granted index.
    always_comb begin
        arb_ptr   = (state_q == StGrant) ? gnt_idx_q : ptr_q;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (MODE == 1) begin
                cand = IDXW'(k);
            end else begin
                cand = IDXW'((32'(arb_ptr) + 32'd1 + k) % N);
            end
            if (!win_found && i_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef LIBSV_ROUND_ROBIN_ARBITER_LOCK_EN
    assign lock_hold = i_lock && i_req[gnt_idx_q];
`else
    assign lock_hold = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        valid_d   = valid_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_d     = One << win_idx;
                    gnt_idx_d = win_idx;
                    valid_d   = 1'b1;
                    state_d   = StGrant;
                end
            end
            StGrant: begin
                if (i_ack) begin
                    if (lock_hold) begin
                        // Burst continues on the same requester; no credit consumed.
                        ptr_d = ptr_q;
                    end else begin
                        ptr_d = gnt_idx_q;
                        if (win_found) begin
                            gnt_d     = One << win_idx;
                            gnt_idx_d = win_idx;
                        end else begin
                            gnt_d     = '0;
                            gnt_idx_d = '0;
                            valid_d   = 1'b0;
                            state_d   = StIdle;
                        end
                    end
                end else if (!i_req[gnt_idx_q]) begin
                    gnt_d     = '0;
                    gnt_idx_d = '0;
                    valid_d   = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ptr_q     <= IDXW'(N - 1);
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
            valid_q   <= valid_d;
        end
    end

    assign o_gnt     = gnt_q;
    assign o_gnt_idx = gnt_idx_q;
    assign o_valid   = valid_q;

endmodule
